// File: rtl/key_repeat_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, detect presses and
// generate frame-aligned action pulses with optional per-channel auto-repeat.
module key_repeat_conditioner #(
    parameter int                N_CH         = 3,
    parameter int                DEB_CYCLES   = 250000,
    parameter int                ACTIVE_LOW   = 1,
    parameter logic [N_CH-1:0]   REPEAT_MASK  = N_CH'(3'b110),
    parameter int                REPEAT_DELAY = 20,
    parameter int                REPEAT_RATE  = 5
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [N_CH-1:0]   keys_raw,
    input  logic              tick,
    input  logic              flush,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   action
);

    localparam int DW    = $clog2(DEB_CYCLES + 1);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW    = $clog2(T_MAX + 1);

    // Compare against "one less" so the toggle happens on the cycle the count would reach the limit.
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [N_CH-1:0] w_keys;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_level;
    logic [N_CH-1:0] r_level_d;
    logic [DW-1:0]   r_deb_cnt [N_CH];

    logic [N_CH-1:0] w_press;

    rpt_state_t      r_state     [N_CH];
    rpt_state_t      w_state_nxt [N_CH];
    logic [TW-1:0]   r_tcnt      [N_CH];
    logic [TW-1:0]   w_tcnt_nxt  [N_CH];

    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] w_pending_nxt;
    logic [N_CH-1:0] r_action;
    logic [N_CH-1:0] w_action_nxt;
    logic [N_CH-1:0] w_set;

    assign w_keys = (ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;

    // NOTE: every clocked block uses non-blocking assignments so all flops sample
    // pre-edge values; blocking here would collapse the two synchroniser stages into one.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= w_keys;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < N_CH; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_level[i]   <= ~r_level[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_press = r_level & ~r_level_d;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pending <= '0;
            r_action  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_tcnt[i]  <= '0;
            end
        end else begin
            r_pending <= w_pending_nxt;
            r_action  <= w_action_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tcnt[i]  <= w_tcnt_nxt[i];
            end
        end
    end

    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_tcnt_nxt    = r_tcnt;
        w_pending_nxt = r_pending;
        w_action_nxt  = '0;
        w_set         = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (flush) begin
                w_state_nxt[i]   = ST_IDLE;
                w_tcnt_nxt[i]    = '0;
                w_pending_nxt[i] = 1'b0;
            end else begin
                if (!r_level[i]) begin
                    // Release always re-arms the channel; a pending action survives it.
                    w_state_nxt[i] = ST_IDLE;
                    w_tcnt_nxt[i]  = '0;
                end else begin
                    unique case (r_state[i])
                        ST_IDLE: begin
                            if (w_press[i] && REPEAT_MASK[i]) begin
                                w_state_nxt[i] = ST_DELAY;
                                w_tcnt_nxt[i]  = '0;
                            end
                        end
                        ST_DELAY: begin
                            if (tick) begin
                                if (r_tcnt[i] == DELAY_LAST) begin
                                    w_set[i]       = 1'b1;
                                    w_tcnt_nxt[i]  = '0;
                                    w_state_nxt[i] = ST_REPEAT;
                                end else begin
                                    w_tcnt_nxt[i] = r_tcnt[i] + TW'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (tick) begin
                                if (r_tcnt[i] == RATE_LAST) begin
                                    w_set[i]      = 1'b1;
                                    w_tcnt_nxt[i] = '0;
                                end else begin
                                    w_tcnt_nxt[i] = r_tcnt[i] + TW'(1);
                                end
                            end
                        end
                        default: begin
                            w_state_nxt[i] = ST_IDLE;
                            w_tcnt_nxt[i]  = '0;
                        end
                    endcase
                end

                w_set[i] = w_set[i] | w_press[i];
                if (tick) begin
                    w_action_nxt[i]  = r_pending[i] | w_set[i];
                    w_pending_nxt[i] = 1'b0;
                end else begin
                    w_pending_nxt[i] = r_pending[i] | w_set[i];
                end
            end
        end
    end

    assign level  = r_level;
    assign action = r_action;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Directed bench for key_repeat_conditioner: expected action pulses are queued per
// tick number when keys are driven and compared every cycle against the DUT output.
module tb_key_repeat_conditioner;

    localparam int N_CH   = 3;
    localparam int DEB    = 4;
    localparam int RDELAY = 3;
    localparam int RRATE  = 2;
    localparam int TPER   = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] keys_raw;
    logic       tick;
    logic       flush;
    logic [2:0] level;
    logic [2:0] action;

    logic [2:0] repeat_mask = 3'b110;

    always #5 clk = ~clk;

    key_repeat_conditioner #(
        .N_CH         (N_CH),
        .DEB_CYCLES   (DEB),
        .ACTIVE_LOW   (1),
        .REPEAT_MASK  (3'b110),
        .REPEAT_DELAY (RDELAY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .keys_raw (keys_raw),
        .tick     (tick),
        .flush    (flush),
        .level    (level),
        .action   (action)
    );

    typedef struct {
        int         t;
        logic [2:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   edges    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick number t is the rising edge numbered t*TPER; coinciding expectations merge.
    task automatic expect_at(input int t, input logic [2:0] v);
        exp_t e;
        e.t   = t;
        e.vec = v;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].t == t) begin
                exp_q[i].vec = exp_q[i].vec | v;
                return;
            end
            if (exp_q[i].t > t) begin
                exp_q.insert(i, e);
                return;
            end
        end
        exp_q.push_back(e);
    endtask

    // Key pressed before edge c+1 and released before edge c_rel+1: level rises on edge
    // c+DEB+2, the press cycle closes at edge c+DEB+3, and repeats fire only on ticks
    // while level is still high (edges up to c_rel+DEB+2).
    task automatic expect_press(input int ch, input int c, input int c_rel);
        int ev;
        int t;
        ev = c + DEB + 3;
        expect_at((ev + TPER - 1) / TPER, 3'(1 << ch));
        if (repeat_mask[ch]) begin
            t = ev / TPER + RDELAY;
            while (t * TPER <= c_rel + DEB + 2) begin
                expect_at(t, 3'(1 << ch));
                t += RRATE;
            end
        end
    endtask

    task automatic cycle();
        logic [2:0] exp_v;
        int         tno;
        tick = ((edges + 1) % TPER == 0);
        @(posedge clk);
        #1;
        edges++;
        exp_v = 3'b000;
        if (tick) begin
            tno = edges / TPER;
            if (exp_q.size() > 0 && exp_q[0].t == tno) begin
                exp_v = exp_q[0].vec;
                void'(exp_q.pop_front());
            end
        end
        check($sformatf("action@edge%0d", edges), action, exp_v);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_phase(input int p);
        while (edges % TPER != p) cycle();
    endtask

    initial begin
        int c;
        int c2;
        int t0;

        resetn   = 1'b0;
        keys_raw = 3'b111;
        flush    = 1'b0;
        tick     = 1'b0;

        run(3);
        check("reset_level", level, 3'b000);
        resetn = 1'b1;

        // Channel 0: no repeat, one pulse; level rises exactly on the 6th edge.
        c = edges;
        expect_press(0, c, c + 40);
        keys_raw[0] = 1'b0;
        run(5);
        check("deb_edge5_level", level, 3'b000);
        run(1);
        check("deb_edge6_level", level, 3'b001);
        run(34);
        keys_raw[0] = 1'b1;
        run(20);
        check("ch0_released_level", level, 3'b000);

        // Glitch one cycle shorter than the debounce length.
        keys_raw[1] = 1'b0;
        run(3);
        keys_raw[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run(1);
            check($sformatf("glitch_level_%0d", k), level, 3'b000);
        end

        // Channel 1 held 100 cycles with press aligned to a tick: repeats at +3, then every 2.
        wait_phase(3);
        c = edges;
        expect_press(1, c, c + 100);
        keys_raw[1] = 1'b0;
        run(100);
        check("ch1_held_level", level, 3'b010);
        keys_raw[1] = 1'b1;
        run(30);
        check("ch1_released_level", level, 3'b000);

        // Channel 2 pressed and released twice (each phase exactly DEB cycles) between ticks.
        wait_phase(4);
        c = edges;
        expect_at((c + DEB + 3 + TPER - 1) / TPER, 3'b100);
        keys_raw[2] = 1'b0;
        run(4);
        keys_raw[2] = 1'b1;
        run(2);
        check("ch2_min_press_level", level, 3'b100);
        run(2);
        keys_raw[2] = 1'b0;
        run(4);
        keys_raw[2] = 1'b1;
        run(30);

        // Channels 0 and 2 pressed together: both pulses in the same tick.
        wait_phase(3);
        c = edges;
        expect_press(0, c, c + 20);
        expect_press(2, c, c + 20);
        keys_raw = 3'b010;
        run(20);
        keys_raw = 3'b111;
        run(20);

        // Flush in the tick cycle that would carry a repeat, then re-press.
        wait_phase(3);
        c  = edges;
        t0 = (c + DEB + 3) / TPER;
        expect_at(t0, 3'b010);
        expect_at(t0 + RDELAY, 3'b010);
        keys_raw[1] = 1'b0;
        run(TPER * (t0 + RDELAY + RRATE) - 1 - edges);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run(40);
        check("flush_held_level", level, 3'b010);
        keys_raw[1] = 1'b1;
        run(20);
        wait_phase(3);
        c2 = edges;
        expect_press(1, c2, c2 + 20);
        keys_raw[1] = 1'b0;
        run(20);
        keys_raw[1] = 1'b1;
        run(20);

        // Reset while channel 1 repeats and channel 0 has a pending press.
        wait_phase(3);
        c  = edges;
        t0 = (c + DEB + 3) / TPER;
        expect_at(t0, 3'b010);
        expect_at(t0 + RDELAY, 3'b010);
        keys_raw[1] = 1'b0;
        run(TPER * (t0 + RDELAY) + 1 - edges);
        keys_raw[0] = 1'b0;
        run(DEB + 3);
        check("pre_reset_level", level, 3'b011);
        resetn   = 1'b0;
        keys_raw = 3'b111;
        #1;
        check("async_reset_level", level, 3'b000);
        check("async_reset_action", action, 3'b000);
        run(3);
        resetn = 1'b1;
        run(40);

        // Key held through reset release yields one normal press.
        keys_raw[0] = 1'b0;
        resetn      = 1'b0;
        run(2);
        resetn = 1'b1;
        c = edges;
        expect_press(0, c, c + 30);
        run(30);
        keys_raw = 3'b111;
        run(20);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_repeat_conditioner.md
KEY_REPEAT_CONDITIONER -- requirements
Module: key_repeat_conditioner

Interface
REQ-001 Parameter N_CH, default 3, number of independent button channels (1..8).
REQ-002 Parameter DEB_CYCLES, default 250000, debounce qualification length in clock cycles (5 ms at 50 MHz); minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = raw inputs are pressed-low (KEY style) and are inverted internally.
REQ-004 Parameter REPEAT_MASK, default N_CH'b110, bit i = 1 enables auto-repeat on channel i.
REQ-005 Parameter REPEAT_DELAY, default 20, ticks from press to first repeat; minimum 1.
REQ-006 Parameter REPEAT_RATE, default 5, ticks between subsequent repeats; minimum 1.
REQ-007 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-008 resetn  input  1  reset, asynchronous and active-low.
REQ-009 keys_raw  input  N_CH  asynchronous raw button levels.
REQ-010 tick  input  1  one-cycle frame strobe (input frame rate, nominally 100 Hz).
REQ-011 flush  input  1  synchronous flush of pending and repeat state.
REQ-012 level  output  N_CH  debounced pressed level per channel (1 = pressed).
REQ-013 action  output  N_CH  registered one-cycle action pulses, frame-aligned.

Function
REQ-014 Per channel: polarity fix, two-flop synchronizer, debouncer, rising-edge detector, auto-repeat FSM, pending flag.
REQ-015 Debouncer: counter increments each cycle that the synchronized input differs from level[i], clears to 0 on any cycle they match.
REQ-016 level[i] toggles and the counter clears on the cycle the counter would reach DEB_CYCLES; counter width clog2(DEB_CYCLES+1), never wraps.
REQ-017 A raw change held stable changes level[i] on the (DEB_CYCLES+2)th rising edge after the change; glitches shorter than DEB_CYCLES cycles never change level.
REQ-018 Press event: level[i] 0->1; sets pending[i] on the next edge.
REQ-019 Repeat FSM states IDLE, DELAY, REPEAT with a tick counter of clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) bits.
REQ-020 IDLE->DELAY on press event (channel with REPEAT_MASK bit set only), counter = 0; unmasked channels stay in IDLE.
REQ-021 DELAY: counter increments per tick; on the tick where it reaches REPEAT_DELAY, set pending[i], counter = 0, go to REPEAT.
REQ-022 REPEAT: counter increments per tick; on the tick where it reaches REPEAT_RATE, set pending[i], counter = 0, stay in REPEAT.
REQ-023 level[i] = 0 forces IDLE and counter = 0 from any state; an already-set pending[i] is kept.
REQ-024 On tick: action[i] <= pending[i] OR (event setting pending[i] in the same cycle); pending[i] cleared; action high exactly one cycle.
REQ-025 No tick: action = 0; pending holds; multiple events between ticks coalesce into one action.
REQ-026 flush: pending cleared, all FSMs to IDLE, action <= 0 that cycle; flush overrides tick and events in the same cycle.
REQ-027 After flush a still-held key produces no further actions until released (level 0) and pressed again.
REQ-028 Channels fully independent; simultaneous actions on several channels in one tick permitted.

Reset
REQ-029 resetn low asynchronously clears synchronizers, level, debounce counters, pending, FSMs (IDLE) and action to 0.
REQ-030 Key held through reset release: level rises after full debounce and yields one normal press event.

Verification (DEB_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2, N_CH=3, ACTIVE_LOW=1, REPEAT_MASK=3'b110, tick every 10 cycles)
REQ-031 keys_raw[0] 1->0 held -> level[0]=1 on 6th edge; exactly one action[0] pulse at next tick; none afterwards (no repeat).
REQ-032 keys_raw[1] low 3 cycles then high -> level[1] stays 0, action[1] never asserted.
REQ-033 keys_raw[1] held 100 cycles -> action[1] at press tick, then after 3 further ticks, then every 2 ticks; stops after release is debounced.
REQ-034 Press and release of channel 2 twice between two ticks -> single action[2] pulse at that tick.
REQ-035 Channel 1 in REPEAT, flush asserted in a tick cycle -> action 0 that cycle, no further actions while held; release and re-press -> action resumes.
REQ-036 resetn low mid-REPEAT with pending set -> level, action, pending 0 immediately; no action at next tick.
